// File: rtl/rgbd_vo_frame_ctrl.sv
// rgbd_vo_frame_ctrl: host shadow configuration bank, frame-start commit to the
// active configuration, and a valid/ready raster pixel-coordinate sequencer.
module rgbd_vo_frame_ctrl #(
    parameter int H_SIZE_BW = 10,
    parameter int V_SIZE_BW = 10,
    parameter int FX_BW     = 35,
    parameter int DEPTH_BW  = 16,
    parameter int REG_DW    = 35
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_reg_wvalid,
    output logic                 o_reg_wready,
    input  logic [3:0]           i_reg_waddr,
    input  logic [REG_DW-1:0]    i_reg_wdata,
    input  logic                 i_reg_ren,
    input  logic [3:0]           i_reg_raddr,
    output logic                 o_reg_rvalid,
    output logic [REG_DW-1:0]    o_reg_rdata,
    input  logic                 i_frame_req,
    output logic                 o_frame_start,
    output logic                 o_frame_done,
    output logic                 o_cfg_err,
    output logic                 o_busy,
    output logic                 o_pix_valid,
    input  logic                 i_pix_ready,
    output logic [H_SIZE_BW-1:0] o_pix_x,
    output logic [V_SIZE_BW-1:0] o_pix_y,
    output logic                 o_pix_sof,
    output logic                 o_pix_eol,
    output logic                 o_pix_eof,
    output logic [H_SIZE_BW-1:0] o_cfg_h_size,
    output logic [V_SIZE_BW-1:0] o_cfg_v_size,
    output logic [FX_BW-1:0]     o_cfg_fx,
    output logic [FX_BW-1:0]     o_cfg_fy,
    output logic [FX_BW-1:0]     o_cfg_cx,
    output logic [FX_BW-1:0]     o_cfg_cy,
    output logic [DEPTH_BW-1:0]  o_cfg_depth_max,
    output logic [DEPTH_BW-1:0]  o_cfg_depth_min
);

    localparam logic [3:0] ADDR_DISABLE   = 4'd0;
    localparam logic [3:0] ADDR_H_SIZE    = 4'd1;
    localparam logic [3:0] ADDR_V_SIZE    = 4'd2;
    localparam logic [3:0] ADDR_FX        = 4'd3;
    localparam logic [3:0] ADDR_FY        = 4'd4;
    localparam logic [3:0] ADDR_CX        = 4'd5;
    localparam logic [3:0] ADDR_CY        = 4'd6;
    localparam logic [3:0] ADDR_DEPTH_MAX = 4'd7;
    localparam logic [3:0] ADDR_DEPTH_MIN = 4'd8;

    localparam logic [H_SIZE_BW-1:0] H_SIZE_RST    = H_SIZE_BW'(32'd640);
    localparam logic [V_SIZE_BW-1:0] V_SIZE_RST    = V_SIZE_BW'(32'd480);
    localparam logic [DEPTH_BW-1:0]  DEPTH_MAX_RST = DEPTH_BW'(32'd20000);
    localparam logic [H_SIZE_BW-1:0] H_ZERO        = H_SIZE_BW'(1'b0);
    localparam logic [V_SIZE_BW-1:0] V_ZERO        = V_SIZE_BW'(1'b0);
    localparam logic [H_SIZE_BW-1:0] H_ONE         = H_SIZE_BW'(1'b1);
    localparam logic [V_SIZE_BW-1:0] V_ONE         = V_SIZE_BW'(1'b1);
    localparam logic [FX_BW-1:0]     FX_ZERO       = FX_BW'(1'b0);
    localparam logic [DEPTH_BW-1:0]  DEPTH_ZERO    = DEPTH_BW'(1'b0);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_COMMIT = 2'd1,
        ST_RUN    = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t               state_q, state_d;

    logic                 sh_disable_q, sh_disable_d;
    logic [H_SIZE_BW-1:0] sh_h_q, sh_h_d;
    logic [V_SIZE_BW-1:0] sh_v_q, sh_v_d;
    logic [FX_BW-1:0]     sh_fx_q, sh_fx_d, sh_fy_q, sh_fy_d;
    logic [FX_BW-1:0]     sh_cx_q, sh_cx_d, sh_cy_q, sh_cy_d;
    logic [DEPTH_BW-1:0]  sh_dmax_q, sh_dmax_d, sh_dmin_q, sh_dmin_d;

    logic [H_SIZE_BW-1:0] act_h_q, act_h_d;
    logic [V_SIZE_BW-1:0] act_v_q, act_v_d;
    logic [FX_BW-1:0]     act_fx_q, act_fx_d, act_fy_q, act_fy_d;
    logic [FX_BW-1:0]     act_cx_q, act_cx_d, act_cy_q, act_cy_d;
    logic [DEPTH_BW-1:0]  act_dmax_q, act_dmax_d, act_dmin_q, act_dmin_d;

    logic [H_SIZE_BW-1:0] x_q, x_d;
    logic [V_SIZE_BW-1:0] y_q, y_d;
    logic                 pix_valid_q, pix_valid_d;
    logic                 sof_q, sof_d, eol_q, eol_d, eof_q, eof_d;
    logic                 frame_start_q, frame_start_d;
    logic                 frame_done_q, frame_done_d;
    logic                 cfg_err_q, cfg_err_d;
    logic                 busy_q, busy_d;
    logic                 wready_q, wready_d;
    logic                 rvalid_q, rvalid_d;
    logic [REG_DW-1:0]    rdata_q, rdata_d, rd_mux;

    logic [8:0]           wr_sel;
    logic [H_SIZE_BW-1:0] h_last;
    logic [V_SIZE_BW-1:0] v_last;

    assign h_last = act_h_q - H_ONE;
    assign v_last = act_v_q - V_ONE;

    // Write decode: one-hot per storage register; RESERVED and 10..15 select nothing.
    always_comb begin
        if (i_reg_wvalid && wready_q && (i_reg_waddr <= ADDR_DEPTH_MIN)) begin
            wr_sel = 9'd1 << i_reg_waddr;
        end else begin
            wr_sel = 9'd0;
        end
    end

    // Shadow bank next state: writes keep the low bits of the data bus.
    always_comb begin
        sh_disable_d = wr_sel[0] ? i_reg_wdata[0]              : sh_disable_q;
        sh_h_d       = wr_sel[1] ? i_reg_wdata[H_SIZE_BW-1:0]  : sh_h_q;
        sh_v_d       = wr_sel[2] ? i_reg_wdata[V_SIZE_BW-1:0]  : sh_v_q;
        sh_fx_d      = wr_sel[3] ? i_reg_wdata[FX_BW-1:0]      : sh_fx_q;
        sh_fy_d      = wr_sel[4] ? i_reg_wdata[FX_BW-1:0]      : sh_fy_q;
        sh_cx_d      = wr_sel[5] ? i_reg_wdata[FX_BW-1:0]      : sh_cx_q;
        sh_cy_d      = wr_sel[6] ? i_reg_wdata[FX_BW-1:0]      : sh_cy_q;
        sh_dmax_d    = wr_sel[7] ? i_reg_wdata[DEPTH_BW-1:0]   : sh_dmax_q;
        sh_dmin_d    = wr_sel[8] ? i_reg_wdata[DEPTH_BW-1:0]   : sh_dmin_q;
    end

    // Read path samples the pre-write shadow value, so a same-cycle write returns old data.
    always_comb begin
        case (i_reg_raddr)
            ADDR_DISABLE:   rd_mux = REG_DW'(sh_disable_q);
            ADDR_H_SIZE:    rd_mux = REG_DW'(sh_h_q);
            ADDR_V_SIZE:    rd_mux = REG_DW'(sh_v_q);
            ADDR_FX:        rd_mux = REG_DW'(sh_fx_q);
            ADDR_FY:        rd_mux = REG_DW'(sh_fy_q);
            ADDR_CX:        rd_mux = REG_DW'(sh_cx_q);
            ADDR_CY:        rd_mux = REG_DW'(sh_cy_q);
            ADDR_DEPTH_MAX: rd_mux = REG_DW'(sh_dmax_q);
            ADDR_DEPTH_MIN: rd_mux = REG_DW'(sh_dmin_q);
            default:        rd_mux = REG_DW'(1'b0);
        endcase
        rvalid_d = i_reg_ren;
        rdata_d  = i_reg_ren ? rd_mux : rdata_q;
    end

    // Frame sequencer next state; pixel flags are precomputed for the coordinate being loaded.
    always_comb begin
        state_d       = state_q;
        x_d           = x_q;
        y_d           = y_q;
        pix_valid_d   = pix_valid_q;
        sof_d         = sof_q;
        eol_d         = eol_q;
        eof_d         = eof_q;
        frame_start_d = 1'b0;
        frame_done_d  = 1'b0;
        cfg_err_d     = 1'b0;
        act_h_d       = act_h_q;
        act_v_d       = act_v_q;
        act_fx_d      = act_fx_q;
        act_fy_d      = act_fy_q;
        act_cx_d      = act_cx_q;
        act_cy_d      = act_cy_q;
        act_dmax_d    = act_dmax_q;
        act_dmin_d    = act_dmin_q;
        case (state_q)
            ST_IDLE: begin
                if (i_frame_req && !sh_disable_q) begin
                    if ((sh_h_q == H_ZERO) || (sh_v_q == V_ZERO)) begin
                        cfg_err_d = 1'b1;
                    end else begin
                        state_d       = ST_COMMIT;
                        frame_start_d = 1'b1;
                        act_h_d       = sh_h_q;
                        act_v_d       = sh_v_q;
                        act_fx_d      = sh_fx_q;
                        act_fy_d      = sh_fy_q;
                        act_cx_d      = sh_cx_q;
                        act_cy_d      = sh_cy_q;
                        act_dmax_d    = sh_dmax_q;
                        act_dmin_d    = sh_dmin_q;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_COMMIT: begin
                state_d     = ST_RUN;
                pix_valid_d = 1'b1;
                x_d         = H_ZERO;
                y_d         = V_ZERO;
                sof_d       = 1'b1;
                eol_d       = (h_last == H_ZERO);
                eof_d       = eol_d && (v_last == V_ZERO);
            end
            ST_RUN: begin
                if (i_pix_ready) begin
                    if (eof_q) begin
                        state_d      = ST_DONE;
                        frame_done_d = 1'b1;
                        pix_valid_d  = 1'b0;
                        sof_d        = 1'b0;
                        eol_d        = 1'b0;
                        eof_d        = 1'b0;
                    end else begin
                        if (eol_q) begin
                            x_d = H_ZERO;
                            y_d = y_q + V_ONE;
                        end else begin
                            x_d = x_q + H_ONE;
                        end
                        sof_d = 1'b0;
                        eol_d = (x_d == h_last);
                        eof_d = eol_d && (y_d == v_last);
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        busy_d   = (state_d != ST_IDLE);
        wready_d = (state_d != ST_COMMIT);
    end

    // All state and outputs register here; reset restores shadow and active defaults.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q       <= ST_IDLE;
            sh_disable_q  <= 1'b0;
            sh_h_q        <= H_SIZE_RST;
            sh_v_q        <= V_SIZE_RST;
            sh_fx_q       <= FX_ZERO;
            sh_fy_q       <= FX_ZERO;
            sh_cx_q       <= FX_ZERO;
            sh_cy_q       <= FX_ZERO;
            sh_dmax_q     <= DEPTH_MAX_RST;
            sh_dmin_q     <= DEPTH_ZERO;
            act_h_q       <= H_SIZE_RST;
            act_v_q       <= V_SIZE_RST;
            act_fx_q      <= FX_ZERO;
            act_fy_q      <= FX_ZERO;
            act_cx_q      <= FX_ZERO;
            act_cy_q      <= FX_ZERO;
            act_dmax_q    <= DEPTH_MAX_RST;
            act_dmin_q    <= DEPTH_ZERO;
            x_q           <= H_ZERO;
            y_q           <= V_ZERO;
            pix_valid_q   <= 1'b0;
            sof_q         <= 1'b0;
            eol_q         <= 1'b0;
            eof_q         <= 1'b0;
            frame_start_q <= 1'b0;
            frame_done_q  <= 1'b0;
            cfg_err_q     <= 1'b0;
            busy_q        <= 1'b0;
            wready_q      <= 1'b1;
            rvalid_q      <= 1'b0;
            rdata_q       <= REG_DW'(1'b0);
        end else begin
            state_q       <= state_d;
            sh_disable_q  <= sh_disable_d;
            sh_h_q        <= sh_h_d;
            sh_v_q        <= sh_v_d;
            sh_fx_q       <= sh_fx_d;
            sh_fy_q       <= sh_fy_d;
            sh_cx_q       <= sh_cx_d;
            sh_cy_q       <= sh_cy_d;
            sh_dmax_q     <= sh_dmax_d;
            sh_dmin_q     <= sh_dmin_d;
            act_h_q       <= act_h_d;
            act_v_q       <= act_v_d;
            act_fx_q      <= act_fx_d;
            act_fy_q      <= act_fy_d;
            act_cx_q      <= act_cx_d;
            act_cy_q      <= act_cy_d;
            act_dmax_q    <= act_dmax_d;
            act_dmin_q    <= act_dmin_d;
            x_q           <= x_d;
            y_q           <= y_d;
            pix_valid_q   <= pix_valid_d;
            sof_q         <= sof_d;
            eol_q         <= eol_d;
            eof_q         <= eof_d;
            frame_start_q <= frame_start_d;
            frame_done_q  <= frame_done_d;
            cfg_err_q     <= cfg_err_d;
            busy_q        <= busy_d;
            wready_q      <= wready_d;
            rvalid_q      <= rvalid_d;
            rdata_q       <= rdata_d;
        end
    end

    assign o_reg_wready    = wready_q;
    assign o_reg_rvalid    = rvalid_q;
    assign o_reg_rdata     = rdata_q;
    assign o_frame_start   = frame_start_q;
    assign o_frame_done    = frame_done_q;
    assign o_cfg_err       = cfg_err_q;
    assign o_busy          = busy_q;
    assign o_pix_valid     = pix_valid_q;
    assign o_pix_x         = x_q;
    assign o_pix_y         = y_q;
    assign o_pix_sof       = sof_q;
    assign o_pix_eol       = eol_q;
    assign o_pix_eof       = eof_q;
    assign o_cfg_h_size    = act_h_q;
    assign o_cfg_v_size    = act_v_q;
    assign o_cfg_fx        = act_fx_q;
    assign o_cfg_fy        = act_fy_q;
    assign o_cfg_cx        = act_cx_q;
    assign o_cfg_cy        = act_cy_q;
    assign o_cfg_depth_max = act_dmax_q;
    assign o_cfg_depth_min = act_dmin_q;

endmodule

// File: tb/tb_rgbd_vo_frame_ctrl.sv
// Self-checking bench for rgbd_vo_frame_ctrl: register bank model plus a raster
// coordinate queue built from nested loops over the committed frame size.
module tb_rgbd_vo_frame_ctrl;

    logic          clk = 1'b0;
    logic          i_rst = 1'b1;
    logic          i_reg_wvalid = 1'b0;
    logic          o_reg_wready;
    logic [3:0]    i_reg_waddr = 4'd0;
    logic [34:0]   i_reg_wdata = 35'd0;
    logic          i_reg_ren = 1'b0;
    logic [3:0]    i_reg_raddr = 4'd0;
    logic          o_reg_rvalid;
    logic [34:0]   o_reg_rdata;
    logic          i_frame_req = 1'b0;
    logic          o_frame_start, o_frame_done, o_cfg_err, o_busy;
    logic          o_pix_valid;
    logic          i_pix_ready = 1'b0;
    logic [9:0]    o_pix_x, o_pix_y;
    logic          o_pix_sof, o_pix_eol, o_pix_eof;
    logic [9:0]    o_cfg_h_size, o_cfg_v_size;
    logic [34:0]   o_cfg_fx, o_cfg_fy, o_cfg_cx, o_cfg_cy;
    logic [15:0]   o_cfg_depth_max, o_cfg_depth_min;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       sof;
        logic       eol;
        logic       eof;
    } pix_t;

    int          tests_run = 0;
    int          tests_failed = 0;
    logic [34:0] exp_sh [0:9];
    logic [34:0] exp_act [0:9];
    logic [191:0] dut_cfg;

    rgbd_vo_frame_ctrl dut (
        .i_clk(clk), .i_rst(i_rst),
        .i_reg_wvalid(i_reg_wvalid), .o_reg_wready(o_reg_wready),
        .i_reg_waddr(i_reg_waddr), .i_reg_wdata(i_reg_wdata),
        .i_reg_ren(i_reg_ren), .i_reg_raddr(i_reg_raddr),
        .o_reg_rvalid(o_reg_rvalid), .o_reg_rdata(o_reg_rdata),
        .i_frame_req(i_frame_req), .o_frame_start(o_frame_start),
        .o_frame_done(o_frame_done), .o_cfg_err(o_cfg_err), .o_busy(o_busy),
        .o_pix_valid(o_pix_valid), .i_pix_ready(i_pix_ready),
        .o_pix_x(o_pix_x), .o_pix_y(o_pix_y),
        .o_pix_sof(o_pix_sof), .o_pix_eol(o_pix_eol), .o_pix_eof(o_pix_eof),
        .o_cfg_h_size(o_cfg_h_size), .o_cfg_v_size(o_cfg_v_size),
        .o_cfg_fx(o_cfg_fx), .o_cfg_fy(o_cfg_fy), .o_cfg_cx(o_cfg_cx), .o_cfg_cy(o_cfg_cy),
        .o_cfg_depth_max(o_cfg_depth_max), .o_cfg_depth_min(o_cfg_depth_min)
    );

    always #5 clk = ~clk;

    assign dut_cfg = {o_cfg_h_size, o_cfg_v_size, o_cfg_fx, o_cfg_fy, o_cfg_cx, o_cfg_cy,
                      o_cfg_depth_max, o_cfg_depth_min};

    function automatic logic [191:0] exp_cfg();
        return {exp_act[1][9:0], exp_act[2][9:0], exp_act[3], exp_act[4], exp_act[5],
                exp_act[6], exp_act[7][15:0], exp_act[8][15:0]};
    endfunction

    function automatic logic [34:0] reg_mask(input int a);
        if (a == 0) return 35'h1;
        else if (a == 1 || a == 2) return 35'h3FF;
        else if (a >= 3 && a <= 6) return 35'h7_FFFF_FFFF;
        else if (a == 7 || a == 8) return 35'hFFFF;
        else return 35'h0;
    endfunction

    task automatic model_reset();
        exp_sh[0] = 35'd0; exp_sh[1] = 35'd640; exp_sh[2] = 35'd480;
        exp_sh[3] = 35'd0; exp_sh[4] = 35'd0;   exp_sh[5] = 35'd0; exp_sh[6] = 35'd0;
        exp_sh[7] = 35'd20000; exp_sh[8] = 35'd0; exp_sh[9] = 35'd0;
        for (int i = 0; i < 10; i++) exp_act[i] = exp_sh[i];
    endtask

    task automatic model_write(input int a, input logic [34:0] d);
        if (a <= 8) exp_sh[a] = d & reg_mask(a);
    endtask

    task automatic model_commit();
        for (int i = 0; i < 10; i++) exp_act[i] = exp_sh[i];
    endtask

    function automatic logic [34:0] model_read(input int a);
        return (a <= 9) ? exp_sh[a] : 35'd0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input int a, input logic [34:0] d);
        i_reg_wvalid = 1'b1; i_reg_waddr = 4'(a); i_reg_wdata = d;
        tick();
        i_reg_wvalid = 1'b0;
        model_write(a, d);
    endtask

    task automatic read_reg(input int a, output logic v, output logic [34:0] d);
        i_reg_ren = 1'b1; i_reg_raddr = 4'(a);
        tick();
        i_reg_ren = 1'b0;
        v = o_reg_rvalid; d = o_reg_rdata;
    endtask

    task automatic test_reset();
        logic v; logic [34:0] d;
        i_rst = 1'b1; tick(); tick();
        i_rst = 1'b0; model_reset();
        tests_run++;
        if ({o_busy, o_pix_valid, o_frame_start, o_frame_done, o_cfg_err, o_reg_rvalid, o_reg_wready} !== 7'b0000001) begin
            tests_failed++;
            $display("FAIL reset_ctrl got %b exp 0000001",
                     {o_busy, o_pix_valid, o_frame_start, o_frame_done, o_cfg_err, o_reg_rvalid, o_reg_wready});
        end
        tests_run++;
        if ({o_pix_x, o_pix_y, o_pix_sof, o_pix_eol, o_pix_eof, o_reg_rdata} !== 58'd0) begin
            tests_failed++; $display("FAIL reset_pix_rdata got nonzero x=%0d y=%0d rdata=%0h", o_pix_x, o_pix_y, o_reg_rdata);
        end
        tests_run++;
        if (dut_cfg !== exp_cfg()) begin
            tests_failed++; $display("FAIL reset_cfg got %h exp %h (h_size %0d)", dut_cfg, exp_cfg(), o_cfg_h_size);
        end
        for (int a = 0; a < 10; a++) begin
            read_reg(a, v, d);
            tests_run++;
            if (v !== 1'b1 || d !== model_read(a)) begin
                tests_failed++; $display("FAIL reset_read a=%0d got v=%b d=%0d exp v=1 d=%0d", a, v, d, model_read(a));
            end
            tick();
            tests_run++;
            if (o_reg_rvalid !== 1'b0) begin
                tests_failed++; $display("FAIL reset_rvalid_pulse a=%0d got %b exp 0", a, o_reg_rvalid);
            end
        end
    endtask

    task automatic test_small_frame();
        int x, y;
        write_reg(1, 35'd4); write_reg(2, 35'd3); write_reg(3, 35'h100_0000);
        i_pix_ready = 1'b1;
        i_frame_req = 1'b1;
        tests_run++;
        if (o_busy !== 1'b0 || o_frame_start !== 1'b0) begin
            tests_failed++; $display("FAIL sf_pre busy=%b start=%b exp 0 0", o_busy, o_frame_start);
        end
        tick();
        i_frame_req = 1'b0;
        model_commit();
        tests_run++;
        if ({o_frame_start, o_busy, o_reg_wready, o_pix_valid} !== 4'b1100) begin
            tests_failed++; $display("FAIL sf_commit got start/busy/wready/valid=%b exp 1100",
                                     {o_frame_start, o_busy, o_reg_wready, o_pix_valid});
        end
        tests_run++;
        if (dut_cfg !== exp_cfg()) begin
            tests_failed++; $display("FAIL sf_cfg got fx=%h h=%0d exp fx=%h h=%0d", o_cfg_fx, o_cfg_h_size, exp_act[3], exp_act[1]);
        end
        tick();
        for (int p = 0; p < 12; p++) begin
            x = p % 4; y = p / 4;
            tests_run++;
            if ({o_pix_valid, o_frame_start, o_frame_done} !== 3'b100 || o_pix_x !== 10'(x) || o_pix_y !== 10'(y) ||
                o_pix_sof !== (p == 0) || o_pix_eol !== (x == 3) || o_pix_eof !== (p == 11)) begin
                tests_failed++;
                $display("FAIL sf_pix p=%0d got v=%b x=%0d y=%0d sof/eol/eof=%b%b%b exp x=%0d y=%0d sof/eol/eof=%b%b%b",
                         p, o_pix_valid, o_pix_x, o_pix_y, o_pix_sof, o_pix_eol, o_pix_eof,
                         x, y, p == 0, x == 3, p == 11);
            end
            tick();
        end
        tests_run++;
        if ({o_frame_done, o_pix_valid, o_busy} !== 3'b101) begin
            tests_failed++; $display("FAIL sf_done got done/valid/busy=%b exp 101", {o_frame_done, o_pix_valid, o_busy});
        end
        tick();
        tests_run++;
        if ({o_frame_done, o_busy} !== 2'b00) begin
            tests_failed++; $display("FAIL sf_idle got done/busy=%b exp 00", {o_frame_done, o_busy});
        end
    endtask

    task automatic test_backpressure();
        logic pat [0:6];
        int hs, c;
        logic stalled;
        logic [19:0] held;
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        write_reg(1, 35'd2); write_reg(2, 35'd2);
        i_frame_req = 1'b1; tick(); i_frame_req = 1'b0; model_commit();
        tick();
        hs = 0; c = 0; stalled = 1'b0; held = 20'd0;
        while (o_frame_done !== 1'b1 && c < 20) begin
            if (stalled) begin
                tests_run++;
                if ({o_pix_x, o_pix_y} !== held || o_pix_valid !== 1'b1) begin
                    tests_failed++; $display("FAIL bp_hold c=%0d got x=%0d y=%0d v=%b exp held x=%0d y=%0d",
                                             c, o_pix_x, o_pix_y, o_pix_valid, held[19:10], held[9:0]);
                end
            end
            i_pix_ready = (c < 7) ? pat[c] : 1'b1;
            stalled = !i_pix_ready;
            held = {o_pix_x, o_pix_y};
            if (i_pix_ready) begin
                tests_run++;
                if (o_pix_x !== 10'(hs % 2) || o_pix_y !== 10'(hs / 2) || o_pix_eof !== (hs == 3)) begin
                    tests_failed++; $display("FAIL bp_pix hs=%0d got x=%0d y=%0d eof=%b exp x=%0d y=%0d eof=%b",
                                             hs, o_pix_x, o_pix_y, o_pix_eof, hs % 2, hs / 2, hs == 3);
                end
                hs++;
            end
            tick(); c++;
        end
        tests_run++;
        if (hs != 4 || c != 7 || o_frame_done !== 1'b1) begin
            tests_failed++; $display("FAIL bp_count got handshakes=%0d cycles=%0d done=%b exp 4 7 1", hs, c, o_frame_done);
        end
        i_pix_ready = 1'b1;
        tick();
    endtask

    task automatic test_shadow_isolation();
        logic v; logic [34:0] d, old_fx;
        int cnt;
        i_pix_ready = 1'b0;
        i_frame_req = 1'b1; tick(); i_frame_req = 1'b0; model_commit();
        tick();
        tests_run++;
        if (o_pix_valid !== 1'b1 || o_reg_wready !== 1'b1) begin
            tests_failed++; $display("FAIL si_run got valid=%b wready=%b exp 1 1", o_pix_valid, o_reg_wready);
        end
        write_reg(1, 35'd8);
        tests_run++;
        if (o_cfg_h_size !== exp_act[1][9:0]) begin
            tests_failed++; $display("FAIL si_active got h=%0d exp %0d", o_cfg_h_size, exp_act[1][9:0]);
        end
        read_reg(1, v, d);
        tests_run++;
        if (v !== 1'b1 || d !== 35'd8) begin
            tests_failed++; $display("FAIL si_shadow_read got v=%b d=%0d exp 1 8", v, d);
        end
        old_fx = exp_sh[3];
        i_reg_wvalid = 1'b1; i_reg_waddr = 4'd3; i_reg_wdata = 35'h5_A5A5_1234;
        i_reg_ren = 1'b1; i_reg_raddr = 4'd3;
        tick();
        i_reg_wvalid = 1'b0; i_reg_ren = 1'b0;
        model_write(3, 35'h5_A5A5_1234);
        tests_run++;
        if (o_reg_rdata !== old_fx) begin
            tests_failed++; $display("FAIL si_collision got %h exp old %h", o_reg_rdata, old_fx);
        end
        read_reg(3, v, d);
        tests_run++;
        if (d !== exp_sh[3]) begin
            tests_failed++; $display("FAIL si_after_write got %h exp %h", d, exp_sh[3]);
        end
        i_pix_ready = 1'b1;
        cnt = 0;
        while (o_frame_done !== 1'b1 && cnt < 20) begin tick(); cnt++; end
        tests_run++;
        if (o_frame_done !== 1'b1 || o_cfg_h_size !== 10'd2) begin
            tests_failed++; $display("FAIL si_frame1_done got done=%b h=%0d exp 1 2", o_frame_done, o_cfg_h_size);
        end
        tick();
        i_frame_req = 1'b1; tick(); i_frame_req = 1'b0; model_commit();
        tests_run++;
        if (o_frame_start !== 1'b1 || dut_cfg !== exp_cfg()) begin
            tests_failed++; $display("FAIL si_commit got start=%b h=%0d exp 1 %0d", o_frame_start, o_cfg_h_size, exp_act[1][9:0]);
        end
        cnt = 0;
        while (o_frame_done !== 1'b1 && cnt < 40) begin tick(); cnt++; end
        tests_run++;
        if (o_frame_done !== 1'b1 || cnt != 17) begin
            tests_failed++; $display("FAIL si_frame2_done got done=%b cycles=%0d exp 1 17", o_frame_done, cnt);
        end
        tick();
    endtask

    task automatic test_rejects();
        logic v; logic [34:0] d;
        write_reg(0, 35'd1);
        i_frame_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests_run++;
            if ({o_frame_start, o_cfg_err, o_busy} !== 3'b000) begin
                tests_failed++; $display("FAIL rj_disable i=%0d got start/err/busy=%b exp 000", i, {o_frame_start, o_cfg_err, o_busy});
            end
        end
        i_frame_req = 1'b0;
        write_reg(0, 35'd0); write_reg(2, 35'd0);
        i_frame_req = 1'b1; tick(); i_frame_req = 1'b0;
        tests_run++;
        if ({o_cfg_err, o_frame_start, o_busy} !== 3'b100) begin
            tests_failed++; $display("FAIL rj_err got err/start/busy=%b exp 100", {o_cfg_err, o_frame_start, o_busy});
        end
        tick();
        tests_run++;
        if ({o_cfg_err, o_busy} !== 2'b00) begin
            tests_failed++; $display("FAIL rj_err_pulse got err/busy=%b exp 00", {o_cfg_err, o_busy});
        end
        write_reg(12, 35'h7_FFFF_FFFF); write_reg(9, 35'h7_FFFF_FFFF); write_reg(15, 35'h1_2345_6789);
        for (int a = 0; a < 16; a++) begin
            read_reg(a, v, d);
            tests_run++;
            if (v !== 1'b1 || d !== model_read(a)) begin
                tests_failed++; $display("FAIL rj_read a=%0d got %h exp %h", a, d, model_read(a));
            end
        end
        tests_run++;
        if (dut_cfg !== exp_cfg()) begin
            tests_failed++; $display("FAIL rj_cfg got %h exp %h", dut_cfg, exp_cfg());
        end
    endtask

    task automatic test_reset_mid_run();
        logic v; logic [34:0] d;
        write_reg(2, 35'd3); write_reg(1, 35'd4);
        i_pix_ready = 1'b1;
        i_frame_req = 1'b1; tick(); i_frame_req = 1'b0; model_commit();
        tick();
        repeat (5) tick();
        tests_run++;
        if (o_pix_valid !== 1'b1 || o_pix_x !== 10'd1 || o_pix_y !== 10'd1) begin
            tests_failed++; $display("FAIL rm_pix5 got v=%b x=%0d y=%0d exp 1 1 1", o_pix_valid, o_pix_x, o_pix_y);
        end
        i_rst = 1'b1; tick(); i_rst = 1'b0;
        model_reset();
        tests_run++;
        if ({o_pix_valid, o_busy, o_frame_done, o_reg_wready} !== 4'b0001 || dut_cfg !== exp_cfg()) begin
            tests_failed++; $display("FAIL rm_after got valid/busy/done/wready=%b h=%0d exp 0001 640",
                                     {o_pix_valid, o_busy, o_frame_done, o_reg_wready}, o_cfg_h_size);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            tests_run++;
            if (o_frame_done !== 1'b0 || o_busy !== 1'b0) begin
                tests_failed++; $display("FAIL rm_no_done i=%0d got done=%b busy=%b exp 0 0", i, o_frame_done, o_busy);
            end
        end
        for (int a = 0; a < 10; a++) begin
            read_reg(a, v, d);
            tests_run++;
            if (d !== model_read(a)) begin
                tests_failed++; $display("FAIL rm_read a=%0d got %0d exp %0d", a, d, model_read(a));
            end
        end
    endtask

    task automatic test_random_frames();
        pix_t q[$];
        pix_t cur, prev, exp_p;
        logic stalled, r, v;
        logic [34:0] wd, d;
        int h, vv, cyc, wa;
        for (int it = 0; it < 5; it++) begin
            h = $urandom_range(1, 5); vv = $urandom_range(1, 4);
            write_reg(1, 35'(h)); write_reg(2, 35'(vv));
            for (int a = 3; a < 9; a++) write_reg(a, 35'({$urandom(), $urandom()}));
            q.delete();
            for (int yy = 0; yy < vv; yy++)
                for (int xx = 0; xx < h; xx++)
                    q.push_back('{x: 10'(xx), y: 10'(yy), sof: (xx == 0 && yy == 0),
                                  eol: (xx == h - 1), eof: (xx == h - 1 && yy == vv - 1)});
            i_frame_req = 1'b1; tick(); i_frame_req = 1'b0; model_commit();
            tests_run++;
            if (o_frame_start !== 1'b1 || dut_cfg !== exp_cfg()) begin
                tests_failed++; $display("FAIL rnd_commit it=%0d got start=%b cfg=%h exp 1 %h", it, o_frame_start, dut_cfg, exp_cfg());
            end
            tick();
            cyc = 0; stalled = 1'b0; prev = '0;
            while (o_frame_done !== 1'b1 && cyc < 300) begin
                i_reg_wvalid = 1'b0;
                cur = '{x: o_pix_x, y: o_pix_y, sof: o_pix_sof, eol: o_pix_eol, eof: o_pix_eof};
                tests_run++;
                if (o_pix_valid !== 1'b1 || o_reg_wready !== 1'b1 || (stalled && cur !== prev)) begin
                    tests_failed++; $display("FAIL rnd_run it=%0d cyc=%0d got valid=%b wready=%b pix=%h exp 1 1 held %h",
                                             it, cyc, o_pix_valid, o_reg_wready, cur, prev);
                end
                r = ($urandom_range(0, 3) != 0);
                i_pix_ready = r; stalled = !r; prev = cur;
                if (r) begin
                    exp_p = (q.size() > 0) ? q.pop_front() : '1;
                    tests_run++;
                    if (cur !== exp_p) begin
                        tests_failed++; $display("FAIL rnd_pix it=%0d got x=%0d y=%0d f=%b%b%b exp x=%0d y=%0d f=%b%b%b",
                                                 it, cur.x, cur.y, cur.sof, cur.eol, cur.eof,
                                                 exp_p.x, exp_p.y, exp_p.sof, exp_p.eol, exp_p.eof);
                    end
                end
                if ($urandom_range(0, 4) == 0) begin
                    wa = $urandom_range(3, 15); wd = 35'({$urandom(), $urandom()});
                    i_reg_wvalid = 1'b1; i_reg_waddr = 4'(wa); i_reg_wdata = wd;
                    model_write(wa, wd);
                end
                tick(); cyc++;
            end
            i_reg_wvalid = 1'b0;
            tests_run++;
            if (o_frame_done !== 1'b1 || q.size() != 0 || dut_cfg !== exp_cfg()) begin
                tests_failed++; $display("FAIL rnd_done it=%0d got done=%b left=%0d cfg=%h exp 1 0 %h",
                                         it, o_frame_done, q.size(), dut_cfg, exp_cfg());
            end
            tick();
            wa = $urandom_range(0, 15);
            read_reg(wa, v, d);
            tests_run++;
            if (v !== 1'b1 || d !== model_read(wa)) begin
                tests_failed++; $display("FAIL rnd_read a=%0d got %h exp %h", wa, d, model_read(wa));
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_small_frame();
        test_backpressure();
        test_shadow_isolation();
        test_rejects();
        test_reset_mid_run();
        test_random_frames();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
